activation_controller: RTL and testbench

ACTIVATION_CONTROLLER -- requirements
Module: activation_controller

---
 rtl/tpu_pkg.sv | 47 ++++
 rtl/act_delay_line.sv | 35 +++
 rtl/activation_controller.sv | 141 ++++++++++++++
 tb/tb_activation_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU types: instruction word, address types and activation function encoding.
package tpu_pkg;

  localparam int unsigned ACCUMULATOR_ADDR_WIDTH = 16;
  localparam int unsigned BUFFER_ADDR_WIDTH      = 24;
  localparam int unsigned LENGTH_WIDTH           = 16;
  localparam int unsigned OPCODE_WIDTH           = 8;
  localparam int unsigned ACT_FUNC_WIDTH         = 4;
  localparam int unsigned ACT_SIGNED_BIT         = 4;

  typedef logic [ACCUMULATOR_ADDR_WIDTH-1:0] accumulator_addr_type;
  typedef logic [BUFFER_ADDR_WIDTH-1:0]      buffer_addr_type;
  typedef logic [LENGTH_WIDTH-1:0]           length_type;
  typedef logic [OPCODE_WIDTH-1:0]           opcode_type;

  typedef enum logic [ACT_FUNC_WIDTH-1:0] {
    ACT_NONE    = 4'd0,
    ACT_RELU    = 4'd1,
    ACT_RELU6   = 4'd2,
    ACT_CRELU   = 4'd3,
    ACT_SIGMOID = 4'd4,
    ACT_TANH    = 4'd5
  } activation_type;

  typedef struct packed {
    opcode_type           opcode;
    accumulator_addr_type acc_addr;
    buffer_addr_type      buffer_addr;
    length_type           length;
  } instr_type;

  // Per-beat control that travels alongside the accumulator data.
  typedef struct packed {
    activation_type func;
    logic           is_signed;
  } act_beat_t;

  localparam int unsigned ACT_BEAT_WIDTH = $bits(act_beat_t);

  function automatic act_beat_t decode_opcode(input logic [ACT_SIGNED_BIT:0] op);
    act_beat_t beat;
    beat.func      = activation_type'(op[ACT_FUNC_WIDTH-1:0]);
    beat.is_signed = op[ACT_SIGNED_BIT];
    return beat;
  endfunction

endpackage

// File: rtl/act_delay_line.sv
// Valid/payload shift register; payload is zeroed for empty slots so taps read 0 when idle.
module act_delay_line #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_enable,
  input  logic                        i_valid,
  input  logic [WIDTH-1:0]            i_payload,
  output logic [DEPTH-1:0]            o_valid,
  output logic [DEPTH-1:0][WIDTH-1:0] o_payload
);

  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0][WIDTH-1:0] r_payload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_payload <= '0;
    end else if (i_enable) begin
      r_valid[0]   <= i_valid;
      r_payload[0] <= i_valid ? i_payload : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_valid[k]   <= r_valid[k-1];
        r_payload[k] <= r_payload[k-1];
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/activation_controller.sv
// Sequences accumulator reads for one activation instruction and aligns function
// select and buffer writes with the read-plus-activation datapath latency.
module activation_controller
  import tpu_pkg::*;
#(
  parameter int unsigned MATRIX_WIDTH     = 14,
  parameter int unsigned ACC_READ_LATENCY = 2,
  parameter int unsigned ACT_LATENCY      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  instr_type            instr,
  input  logic                 instr_enable,
  output accumulator_addr_type acc_to_act_addr,
  output logic                 acc_read_enable,
  output activation_type       activation_function,
  output logic                 is_act_signed,
  output buffer_addr_type      act_to_buf_addr,
  output logic                 buf_write_enable,
  output logic                 busy,
  output logic                 resource_busy
);

  // Both latencies must be at least 1 so the function tap and write tap are real stages.
  localparam int unsigned PIPE_DEPTH = ACC_READ_LATENCY + ACT_LATENCY;
  localparam int unsigned FUNC_TAP   = ACC_READ_LATENCY - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  length_type           r_remaining;
  accumulator_addr_type r_rd_addr;
  logic                 r_rd_en;
  buffer_addr_type      r_wr_addr;
  act_beat_t            r_beat;
  logic                 r_busy;
  logic                 r_res_busy;
  logic                 w_accept;
  logic                 w_pending;
  act_beat_t            w_tap_beat;

  logic [PIPE_DEPTH-1:0]                     w_pipe_valid;
  logic [PIPE_DEPTH-1:0][ACT_BEAT_WIDTH-1:0] w_pipe_payload;

  // Beats that still have to reach the write stage after this cycle.
  assign w_pending = |w_pipe_valid[PIPE_DEPTH-2:0];

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (instr_enable) begin
          w_accept     = 1'b1;
          w_next_state = (instr.length == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_remaining == length_type'(1)) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!w_pending) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_rd_addr   <= '0;
      r_rd_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_beat      <= '0;
      r_busy      <= 1'b0;
      r_res_busy  <= 1'b0;
    end else if (enable) begin
      r_state    <= w_next_state;
      r_busy     <= (w_next_state == ST_ISSUE);
      r_res_busy <= (w_next_state != ST_IDLE) || r_rd_en || w_pending;
      if (w_accept) begin
        r_remaining <= instr.length;
        r_rd_addr   <= instr.acc_addr;
        r_wr_addr   <= instr.buffer_addr;
        r_beat      <= decode_opcode(instr.opcode[ACT_SIGNED_BIT:0]);
        r_rd_en     <= (instr.length != '0);
      end else begin
        if (r_state == ST_ISSUE) begin
          r_remaining <= r_remaining - length_type'(1);
          r_rd_en     <= (r_remaining != length_type'(1));
        end
        if (r_rd_en) begin
          r_rd_addr <= r_rd_addr + accumulator_addr_type'(1);
        end
        if (buf_write_enable) begin
          r_wr_addr <= r_wr_addr + buffer_addr_type'(1);
        end
      end
    end
  end

  // Read strobe enters the alignment line; taps give function select and write strobe.
  act_delay_line #(
    .DEPTH (PIPE_DEPTH),
    .WIDTH (ACT_BEAT_WIDTH)
  ) u_act_delay_line (
    .clk       (clk),
    .rst_n     (rst),
    .i_enable  (enable),
    .i_valid   (r_rd_en),
    .i_payload (r_beat),
    .o_valid   (w_pipe_valid),
    .o_payload (w_pipe_payload)
  );

  assign w_tap_beat = act_beat_t'(w_pipe_payload[FUNC_TAP]);

  assign acc_to_act_addr     = r_rd_addr;
  assign acc_read_enable     = r_rd_en;
  assign activation_function = w_tap_beat.func;
  assign is_act_signed       = w_tap_beat.is_signed;
  assign act_to_buf_addr     = r_wr_addr;
  assign buf_write_enable    = w_pipe_valid[PIPE_DEPTH-1];
  assign busy                = r_busy;
  assign resource_busy       = r_res_busy;

  // Sink for instruction bits and parameters not consumed by this block.
  logic w_unused;
  assign w_unused = ^{instr.opcode[OPCODE_WIDTH-1:ACT_SIGNED_BIT+1], w_pipe_payload,
                      32'(MATRIX_WIDTH)};

endmodule

// File: tb/tb_activation_controller.sv
// Bench for activation_controller: directed scenarios then random traffic against an
// event-schedule model keyed by the number of enabled clock edges since reset.
module tb_activation_controller;
  import tpu_pkg::*;

  localparam int RL = 2;
  localparam int AL = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  instr_type            instr;
  logic                 instr_enable;
  accumulator_addr_type acc_to_act_addr;
  logic                 acc_read_enable;
  activation_type       activation_function;
  logic                 is_act_signed;
  buffer_addr_type      act_to_buf_addr;
  logic                 buf_write_enable;
  logic                 busy;
  logic                 resource_busy;

  activation_controller #(
    .MATRIX_WIDTH     (14),
    .ACC_READ_LATENCY (RL),
    .ACT_LATENCY      (AL)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .instr               (instr),
    .instr_enable        (instr_enable),
    .acc_to_act_addr     (acc_to_act_addr),
    .acc_read_enable     (acc_read_enable),
    .activation_function (activation_function),
    .is_act_signed       (is_act_signed),
    .act_to_buf_addr     (act_to_buf_addr),
    .buf_write_enable    (buf_write_enable),
    .busy                (busy),
    .resource_busy       (resource_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: n counts enabled edges; expected events are scheduled by that index.
  int n;
  int cur_a;
  int cur_len;
  int busy_end;
  accumulator_addr_type exp_rd[int];
  buffer_addr_type      exp_wr[int];
  logic [4:0]           exp_fn[int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_rd.delete();
    exp_wr.delete();
    exp_fn.delete();
    n        = 0;
    cur_a    = -100;
    cur_len  = 0;
    busy_end = -1;
  endtask

  task automatic model_accept(input instr_type ins);
    cur_a   = n;
    cur_len = int'(ins.length);
    busy_end = (cur_len == 0) ? n + 1 : n + cur_len + RL + AL;
    for (int k = 0; k < cur_len; k++) begin
      exp_rd[n + 1 + k]           = accumulator_addr_type'(int'(ins.acc_addr) + k);
      exp_fn[n + 1 + k + RL]      = ins.opcode[4:0];
      exp_wr[n + 1 + k + RL + AL] = buffer_addr_type'(int'(ins.buffer_addr) + k);
    end
  endtask

  task automatic check_outputs();
    logic       rd_exp;
    logic       wr_exp;
    logic [4:0] fn;
    logic       busy_exp;
    logic       res_exp;
    rd_exp   = exp_rd.exists(n);
    wr_exp   = exp_wr.exists(n);
    fn       = exp_fn.exists(n) ? exp_fn[n] : 5'd0;
    busy_exp = (cur_len > 0) && (n >= cur_a + 1) && (n <= cur_a + cur_len);
    res_exp  = (n >= cur_a + 1) && (n <= busy_end);
    chk("acc_read_enable", 64'(acc_read_enable), 64'(rd_exp));
    if (rd_exp) chk("acc_to_act_addr", 64'(acc_to_act_addr), 64'(exp_rd[n]));
    chk("buf_write_enable", 64'(buf_write_enable), 64'(wr_exp));
    if (wr_exp) chk("act_to_buf_addr", 64'(act_to_buf_addr), 64'(exp_wr[n]));
    chk("activation_function", 64'(activation_function), 64'(fn[3:0]));
    chk("is_act_signed", 64'(is_act_signed), 64'(fn[4]));
    chk("busy", 64'(busy), 64'(busy_exp));
    chk("resource_busy", 64'(resource_busy), 64'(res_exp));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_acc_addr"}, 64'(acc_to_act_addr), 64'd0);
    chk({tag, "_rd_en"}, 64'(acc_read_enable), 64'd0);
    chk({tag, "_func"}, 64'(activation_function), 64'd0);
    chk({tag, "_signed"}, 64'(is_act_signed), 64'd0);
    chk({tag, "_buf_addr"}, 64'(act_to_buf_addr), 64'd0);
    chk({tag, "_wr_en"}, 64'(buf_write_enable), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_res_busy"}, 64'(resource_busy), 64'd0);
  endtask

  // Called at a falling edge: check, drive, advance one clock, return at the next falling edge.
  task automatic step(input logic en, input logic ie, input instr_type ins);
    check_outputs();
    enable       = en;
    instr_enable = ie;
    instr        = ins;
    if (en && ie && (n > busy_end)) model_accept(ins);
    @(posedge clk);
    if (en) n++;
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    instr_type z;
    z = '0;
    repeat (cycles) step(1'b1, 1'b0, z);
  endtask

  function automatic instr_type mk(input logic [7:0] op, input accumulator_addr_type a,
                                   input buffer_addr_type b, input length_type len);
    instr_type t;
    t.opcode      = op;
    t.acc_addr    = a;
    t.buffer_addr = b;
    t.length      = len;
    return t;
  endfunction

  function automatic instr_type rand_instr();
    logic [7:0] op;
    op = {3'($urandom), 1'($urandom), 4'($urandom_range(0, 5))};
    return mk(op, accumulator_addr_type'($urandom), buffer_addr_type'($urandom),
              length_type'($urandom_range(0, 9)));
  endfunction

  initial begin
    instr_type z;
    z            = '0;
    rst          = 1'b0;
    enable       = 1'b0;
    instr_enable = 1'b0;
    instr        = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    // Basic transfer: ReLU, signed.
    step(1'b1, 1'b1, mk(8'h11, 16'd5, 24'd100, 16'd4));
    idle(12);

    // Accumulator and buffer address wrap.
    step(1'b1, 1'b1, mk(8'h03, 16'hFFFE, 24'hFFFFFF, 16'd3));
    idle(10);

    // Zero length.
    step(1'b1, 1'b1, mk(8'h02, 16'd7, 24'd9, 16'd0));
    idle(4);

    // Second instruction during ISSUE is ignored.
    step(1'b1, 1'b1, mk(8'h14, 16'd20, 24'd200, 16'd5));
    step(1'b1, 1'b0, z);
    step(1'b1, 1'b1, mk(8'h05, 16'd40, 24'd400, 16'd7));
    idle(12);

    // Enable dropped for 3 cycles mid-ISSUE; an instr strobe while disabled in IDLE is dropped.
    step(1'b1, 1'b1, mk(8'h12, 16'd60, 24'd300, 16'd6));
    step(1'b1, 1'b0, z);
    step(1'b1, 1'b0, z);
    repeat (3) step(1'b0, 1'b0, z);
    idle(12);
    step(1'b0, 1'b1, mk(8'h01, 16'd1, 24'd1, 16'd2));
    idle(3);

    // Asynchronous reset during DRAIN, then immediate reuse.
    step(1'b1, 1'b1, mk(8'h13, 16'd80, 24'd500, 16'd3));
    repeat (5) step(1'b1, 1'b0, z);
    #2 rst = 1'b0;
    #1 check_all_zero("reset_mid_drain");
    @(negedge clk);
    check_all_zero("reset_hold");
    rst = 1'b1;
    model_reset();
    step(1'b1, 1'b1, mk(8'h04, 16'd33, 24'd700, 16'd2));
    idle(12);

    // Random traffic with enable gaps and strobes while busy.
    repeat (400) step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0), rand_instr());
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
